// File: rtl/pila_sync.sv
// -----------------------------------------------------------------------------
// pila_sync -- synchronous LIFO for return addresses (jal/ret).
//
// Holds up to DEPTH entries of WIDTH bits. The top of stack is presented
// combinationally on outpop so a pop consumes the value visible in the same
// cycle. Rejected operations raise sticky overflow/underflow flags that hold
// until clr_err or reset.
//
// Ports
//   clk        in   1      clock, all state changes on posedge
//   reset      in   1      synchronous, active-high; overrides push/pop/clr_err
//   push       in   1      write inpush onto the stack
//   pop        in   1      remove the top entry
//   clr_err    in   1      clear overflow/underflow (a new error in the same
//                          cycle wins)
//   inpush     in   WIDTH  data to push
//   outpop     out  WIDTH  top of stack, 0 when empty
//   empty      out  1      count == 0
//   full       out  1      count == DEPTH
//   count      out  CW     number of valid entries
//   overflow   out  1      sticky: push rejected while full
//   underflow  out  1      sticky: pop rejected while empty
// -----------------------------------------------------------------------------
module pila_sync #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] inpush,
    output logic [WIDTH-1:0] outpop,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic [CW-1:0]    w_top_idx;
    logic [CW-1:0]    w_wr_idx;
    logic             w_wr_en;
    logic [CW-1:0]    w_count_next;
    logic             w_ov_set;
    logic             w_ud_set;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_top_idx = r_count - CW'(1);

    // Push+pop on a non-empty stack overwrites the top in place; every other
    // accepted push (including push+pop on empty) writes the next free slot.
    assign w_wr_idx = (push && pop && !w_empty) ? w_top_idx : r_count;
    assign w_wr_en  = push && (pop || !w_full);

    // A lone push into a full stack is the only overflow; any pop seen while
    // empty is an underflow, even when paired with a push that is accepted.
    assign w_ov_set = push && !pop && w_full;
    assign w_ud_set = pop && w_empty;

    always_comb begin
        w_count_next = r_count;
        unique case ({push, pop})
            2'b10:   if (!w_full)  w_count_next = r_count + CW'(1);
            2'b01:   if (!w_empty) w_count_next = r_count - CW'(1);
            2'b11:   if (w_empty)  w_count_next = CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // NOTE: storage carries no reset; its contents are never visible until
    // written because outpop is gated by count, and resetting an array would
    // force it out of RAM-style inference.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_en) begin
            r_mem[w_wr_idx] <= inpush;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_next;
            // Set wins over clr_err when both happen in one cycle.
            r_overflow  <= w_ov_set | (r_overflow  & ~clr_err);
            r_underflow <= w_ud_set | (r_underflow & ~clr_err);
        end
    end

    assign outpop    = w_empty ? '0 : r_mem[w_top_idx];
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_pila_sync.sv
// -----------------------------------------------------------------------------
// tb_pila_sync -- checks two pila_sync instances side by side: the default
// configuration (WIDTH=10, DEPTH=8) and a small one (WIDTH=12, DEPTH=5).
// Both see the same control stimulus; the reference model keeps each stack as
// a queue of values and applies the push/pop/error rules directly.
// -----------------------------------------------------------------------------
module tb_pila_sync;

    localparam int WA = 10, DA = 8, CWA = $clog2(DA + 1);
    localparam int WB = 12, DB = 5, CWB = $clog2(DB + 1);

    logic            clk = 1'b0;
    logic            reset, push, pop, clr_err;
    logic [11:0]     inpush;

    logic [WA-1:0]   outpop_a;
    logic            empty_a, full_a, overflow_a, underflow_a;
    logic [CWA-1:0]  count_a;
    logic [WB-1:0]   outpop_b;
    logic            empty_b, full_b, overflow_b, underflow_b;
    logic [CWB-1:0]  count_b;

    always #5 clk = ~clk;

    pila_sync #(.WIDTH(WA), .DEPTH(DA)) dut_a (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .clr_err(clr_err),
        .inpush(inpush[WA-1:0]), .outpop(outpop_a), .empty(empty_a),
        .full(full_a), .count(count_a), .overflow(overflow_a),
        .underflow(underflow_a)
    );

    pila_sync #(.WIDTH(WB), .DEPTH(DB)) dut_b (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .clr_err(clr_err),
        .inpush(inpush), .outpop(outpop_b), .empty(empty_b),
        .full(full_b), .count(count_b), .overflow(overflow_b),
        .underflow(underflow_b)
    );

    // Reference model: one queue per instance, back of queue = top of stack.
    logic [11:0] stk [2][$];
    bit          m_ov [2];
    bit          m_ud [2];
    int          depth_of [2] = '{DA, DB};
    logic [11:0] mask_of  [2] = '{12'h3FF, 12'hFFF};

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit p, input bit q, input bit c,
                              input logic [11:0] d);
        for (int k = 0; k < 2; k++) begin
            logic [11:0] dk;
            bit          ov_now;
            bit          ud_now;
            dk     = d & mask_of[k];
            ov_now = 1'b0;
            ud_now = 1'b0;
            if (rst) begin
                stk[k].delete();
                m_ov[k] = 1'b0;
                m_ud[k] = 1'b0;
            end else begin
                if (p && q) begin
                    if (stk[k].size() == 0) begin
                        stk[k].push_back(dk);
                        ud_now = 1'b1;
                    end else begin
                        void'(stk[k].pop_back());
                        stk[k].push_back(dk);
                    end
                end else if (p) begin
                    if (stk[k].size() == depth_of[k]) ov_now = 1'b1;
                    else                              stk[k].push_back(dk);
                end else if (q) begin
                    if (stk[k].size() == 0) ud_now = 1'b1;
                    else                    void'(stk[k].pop_back());
                end
                m_ov[k] = ov_now || (m_ov[k] && !c);
                m_ud[k] = ud_now || (m_ud[k] && !c);
            end
        end
    endtask

    function automatic logic [11:0] exp_top(input int k);
        if (stk[k].size() == 0) return 12'h000;
        return stk[k][stk[k].size() - 1];
    endfunction

    task automatic compare_all();
        check("a_outpop",    32'(outpop_a),    32'(exp_top(0)));
        check("a_count",     32'(count_a),     32'(stk[0].size()));
        check("a_empty",     32'(empty_a),     32'(stk[0].size() == 0));
        check("a_full",      32'(full_a),      32'(stk[0].size() == DA));
        check("a_overflow",  32'(overflow_a),  32'(m_ov[0]));
        check("a_underflow", 32'(underflow_a), 32'(m_ud[0]));
        check("b_outpop",    32'(outpop_b),    32'(exp_top(1)));
        check("b_count",     32'(count_b),     32'(stk[1].size()));
        check("b_empty",     32'(empty_b),     32'(stk[1].size() == 0));
        check("b_full",      32'(full_b),      32'(stk[1].size() == DB));
        check("b_overflow",  32'(overflow_b),  32'(m_ov[1]));
        check("b_underflow", 32'(underflow_b), 32'(m_ud[1]));
    endtask

    // Drive at the falling edge, let the rising edge act, compare at the next
    // falling edge.
    task automatic step(input bit rst, input bit p, input bit q, input bit c,
                        input logic [11:0] d);
        reset   = rst;
        push    = p;
        pop     = q;
        clr_err = c;
        inpush  = d;
        @(posedge clk);
        model_step(rst, p, q, c, d);
        @(negedge clk);
        reset   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
        compare_all();
    endtask

    initial begin
        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
        inpush  = '0;
        @(negedge clk);

        // Reset, then idle.
        step(1, 0, 0, 0, 12'h000);
        step(0, 0, 0, 0, 12'h000);

        // Fill past full, one rejected push, then drain in LIFO order.
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 0, 12'(i));
        step(0, 1, 0, 0, 12'h3FF);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 12'h000);
        step(0, 0, 0, 1, 12'h000);

        // Underflow, clear, then clear and new underflow together.
        step(0, 0, 1, 0, 12'h000);
        step(0, 0, 0, 1, 12'h000);
        step(0, 0, 1, 1, 12'h000);
        step(0, 0, 0, 1, 12'h000);

        // Replace-top with push+pop, then pop back to the older entry.
        step(0, 1, 0, 0, 12'h055);
        step(0, 1, 0, 0, 12'h0AA);
        step(0, 1, 1, 0, 12'h123);
        step(0, 0, 1, 0, 12'h000);
        step(0, 0, 1, 0, 12'h000);

        // Push+pop on empty, then push+pop on a full stack.
        step(0, 1, 1, 0, 12'h200);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 12'($urandom_range(0, 4095)));
        step(0, 0, 0, 1, 12'h000);
        step(0, 1, 1, 0, 12'hABC);

        // Reset while pushing mid-fill.
        step(1, 0, 0, 0, 12'h000);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 12'h100 + 12'(i));
        step(1, 1, 0, 0, 12'h111);
        step(0, 0, 0, 0, 12'h000);

        // Random traffic with occasional clears and rare resets.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            step(r == 0,
                 $urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 10,
                 12'($urandom_range(0, 4095)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
